// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid
// buffer. A downstream stall reaches upstream one cycle later without losing
// data. All outputs are decoded from registered state only, so there is no
// combinational path from any input to any output.
//
// Ports:
//   clk        clock, all state updates on rising edge
//   reset      asynchronous, active-high reset
//   flush      synchronous flush, discards all held entries
//   in_valid   upstream has data on in_data
//   in_ready   stage can accept data this cycle
//   in_data    upstream data bundle
//   out_valid  out_data holds a valid entry
//   out_ready  downstream accepts out_data this cycle
//   out_data   head entry (main register)
//   occupancy  number of held entries (0, 1 or 2)
module pipe_skid_reg #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_fire;
  logic             out_fire;

  // Handshake outputs depend on registered state only.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Occupancy decode.
  always_comb begin
    occupancy = 2'd0;
    case (state)
      ONE:     occupancy = 2'd1;
      TWO:     occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // State and data registers; flush outranks every handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= EMPTY;
      main_q <= RESET_VAL;
      skid_q <= RESET_VAL;
    end else if (flush) begin
      state  <= EMPTY;
      main_q <= RESET_VAL;
      skid_q <= RESET_VAL;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_q <= in_data;
            state  <= ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_q <= in_data;
          end else if (in_fire) begin
            // Head is stalled: park the new beat behind it.
            skid_q <= in_data;
            state  <= TWO;
          end else if (out_fire) begin
            state  <= EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            main_q <= skid_q;
            state  <= ONE;
          end
        end
        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

endmodule
